regfile_mp_sweep: RTL and testbench



---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_bypass_mux.sv | 39 +++
 rtl/regfile_mp_sweep.sv | 113 +++++++++++
 tb/tb_regfile_mp_sweep.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and the preset table for the swept register file.
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned WR_PORTS = 2;
    localparam int unsigned PRESET_W = 32;

    // Value loaded into each entry by the clear sweep; callers truncate to DATA_W.
    function automatic logic [PRESET_W-1:0] preset_value(input int unsigned idx);
        logic [PRESET_W-1:0] v;
        v = '0;
        case (idx)
            1:       v = 32'd1;
            2:       v = 32'd2;
            10:      v = 32'h1001_0000;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port output select: ready gating, hard-wired zero entry, write bypass.
module regfile_bypass_mux #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [DATA_W-1:0]                  i_stored,
    input  logic [ADDR_W-1:0]                  i_rd_index,
    input  logic [regfile_pkg::WR_PORTS-1:0]   i_wr_en,
    input  logic [ADDR_W-1:0]                  i_wr_index_a,
    input  logic [DATA_W-1:0]                  i_wr_data_a,
    input  logic [ADDR_W-1:0]                  i_wr_index_b,
    input  logic [DATA_W-1:0]                  i_wr_data_b,
    input  logic                               i_ready,
    output logic [DATA_W-1:0]                  o_rd_data_c
);

    logic w_hit_a;
    logic w_hit_b;

    assign w_hit_a = (BYPASS != 0) && i_wr_en[0] && (i_wr_index_a == i_rd_index);
    assign w_hit_b = (BYPASS != 0) && i_wr_en[1] && (i_wr_index_b == i_rd_index);

    // Priority: not ready, zero entry, load-port bypass, ALU-port bypass, stored value
    always_comb begin
        o_rd_data_c = i_stored;
        if (!i_ready) begin
            o_rd_data_c = '0;
        end else if ((ZERO_REG != 0) && (i_rd_index == '0)) begin
            o_rd_data_c = '0;
        end else if (w_hit_b) begin
            o_rd_data_c = i_wr_data_b;
        end else if (w_hit_a) begin
            o_rd_data_c = i_wr_data_a;
        end
    end

endmodule

// File: rtl/regfile_mp_sweep.sv
// Multi-read, dual-write register file cleared by a one-entry-per-cycle preset sweep.
module regfile_mp_sweep #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                                      clock,
    input  logic                                      clear,
    output logic                                      ready,
    input  logic [NUM_RD*ADDR_W-1:0]                  rd_index,
    output logic [NUM_RD*DATA_W-1:0]                  rd_data,
    input  logic [regfile_pkg::WR_PORTS-1:0]          wr_en,
    input  logic [regfile_pkg::WR_PORTS*ADDR_W-1:0]   wr_index,
    input  logic [regfile_pkg::WR_PORTS*DATA_W-1:0]   wr_data
);

    import regfile_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_sweep_idx;
    logic              r_ready;
    logic              w_sweep_last;
    logic              w_run;
    logic [ADDR_W-1:0] w_idx_a;
    logic [ADDR_W-1:0] w_idx_b;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;
    logic              w_we_a;
    logic              w_we_b;

    assign w_idx_a  = wr_index[0      +: ADDR_W];
    assign w_idx_b  = wr_index[ADDR_W +: ADDR_W];
    assign w_data_a = wr_data[0       +: DATA_W];
    assign w_data_b = wr_data[DATA_W  +: DATA_W];

    // Next state: leave the sweep once the last entry has been preset
    always_comb begin
        w_state_next = r_state;
        w_sweep_last = (r_sweep_idx == ADDR_W'(DEPTH - 1));
        case (r_state)
            SWEEP: if (w_sweep_last) w_state_next = RUN;
            RUN:   w_state_next = RUN;
        endcase
    end

    // State, sweep counter and ready; clear restarts the sweep from any state
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= SWEEP;
            r_sweep_idx <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == RUN);
            if (r_state == SWEEP) begin
                r_sweep_idx <= r_sweep_idx + ADDR_W'(1);
            end
        end
    end

    // Write arbitration: only in RUN, zero entry discarded, port B wins a shared index
    assign w_run  = (r_state == RUN) && !clear;
    assign w_we_b = w_run && wr_en[1] && !((ZERO_REG != 0) && (w_idx_b == '0));
    assign w_we_a = w_run && wr_en[0] && !((ZERO_REG != 0) && (w_idx_a == '0))
                    && !(wr_en[1] && (w_idx_a == w_idx_b));

    // Array update: preset during the sweep, arbitrated writes in RUN; no reset keeps it RAM-like
    always_ff @(posedge clock) begin
        if (!clear && (r_state == SWEEP)) begin
            r_mem[r_sweep_idx] <= DATA_W'(preset_value(32'(r_sweep_idx)));
        end else begin
            if (w_we_a) r_mem[w_idx_a] <= w_data_a;
            if (w_we_b) r_mem[w_idx_b] <= w_data_b;
        end
    end

`ifndef SYNTHESIS
    // Trace of committed writes
    always @(posedge clock) begin
        if (w_we_a) $display("regfile write port A idx %0d data %h", w_idx_a, w_data_a);
        if (w_we_b) $display("regfile write port B idx %0d data %h", w_idx_b, w_data_b);
    end
`endif

    // One output select per read port
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .i_stored     (r_mem[rd_index[p*ADDR_W +: ADDR_W]]),
            .i_rd_index   (rd_index[p*ADDR_W +: ADDR_W]),
            .i_wr_en      (wr_en),
            .i_wr_index_a (w_idx_a),
            .i_wr_data_a  (w_data_a),
            .i_wr_index_b (w_idx_b),
            .i_wr_data_b  (w_data_b),
            .i_ready      (r_ready),
            .o_rd_data_c  (rd_data[p*DATA_W +: DATA_W])
        );
    end

    assign ready = r_ready;

endmodule

// File: tb/tb_regfile_mp_sweep.sv
// Randomised self-checking bench: instance A (32x32, 2 reads, bypass, zero reg) and
// instance B (8x16, 4 reads, no bypass, no zero reg) against an array model.
module tb_regfile_mp_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_clear, a_ready;
    logic [9:0]  a_rd_index;
    logic [63:0] a_rd_data;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_index;
    logic [63:0] a_wr_data;

    logic        b_clear, b_ready;
    logic [11:0] b_rd_index;
    logic [63:0] b_rd_data;
    logic [1:0]  b_wr_en;
    logic [5:0]  b_wr_index;
    logic [31:0] b_wr_data;

    regfile_mp_sweep #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clock(clk), .clear(a_clear), .ready(a_ready), .rd_index(a_rd_index), .rd_data(a_rd_data),
        .wr_en(a_wr_en), .wr_index(a_wr_index), .wr_data(a_wr_data));

    regfile_mp_sweep #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clock(clk), .clear(b_clear), .ready(b_ready), .rd_index(b_rd_index), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_index(b_wr_index), .wr_data(b_wr_data));

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_a [32];
    logic [15:0] m_b [8];

    function automatic logic [31:0] spec_preset(input int idx);
        if (idx == 1)  return 32'd1;
        if (idx == 2)  return 32'd2;
        if (idx == 10) return 32'h1001_0000;
        return 32'd0;
    endfunction

    task automatic load_presets();
        for (int i = 0; i < 32; i++) m_a[i] = spec_preset(i);
        for (int i = 0; i < 8; i++)  m_b[i] = 16'(spec_preset(i));
    endtask

    // Value a read of idx should see on A this cycle given the live writes
    function automatic logic [31:0] exp_a(input logic [4:0] idx, input logic [1:0] en,
                                          input logic [4:0] ia, input logic [31:0] da,
                                          input logic [4:0] ib, input logic [31:0] db);
        if (idx == 5'd0)          return 32'd0;
        if (en[1] && ib == idx)   return db;
        if (en[0] && ia == idx)   return da;
        return m_a[idx];
    endfunction

    task automatic commit_a(input logic [1:0] en, input logic [4:0] ia, input logic [31:0] da,
                            input logic [4:0] ib, input logic [31:0] db);
        if (en[0] && ia != 5'd0) m_a[ia] = da;
        if (en[1] && ib != 5'd0) m_a[ib] = db;
    endtask

    task automatic commit_b(input logic [1:0] en, input logic [2:0] ia, input logic [15:0] da,
                            input logic [2:0] ib, input logic [15:0] db);
        if (en[0]) m_b[ia] = da;
        if (en[1]) m_b[ib] = db;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] en, input logic [4:0] ia, input logic [31:0] da,
                           input logic [4:0] ib, input logic [31:0] db);
        a_wr_en = en; a_wr_index = {ib, ia}; a_wr_data = {db, da};
    endtask

    task automatic drive_b(input logic [1:0] en, input logic [2:0] ia, input logic [15:0] da,
                           input logic [2:0] ib, input logic [15:0] db);
        b_wr_en = en; b_wr_index = {ib, ia}; b_wr_data = {db, da};
    endtask

    task automatic test_reset();
        int ra, rb, bad;
        ra = 0; rb = 0; bad = 0;
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive_b(2'b00, 3'd0, 16'd0, 3'd0, 16'd0);
        a_rd_index = {5'd2, 5'd1};
        b_rd_index = {3'd2, 3'd1, 3'd2, 3'd1};
        a_clear = 1'b1; b_clear = 1'b1;
        tick();
        a_clear = 1'b0; b_clear = 1'b0;
        n_total++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL reset_ready: got a=%b b=%b expected 0", a_ready, b_ready);
        else n_pass++;
        n_total++;
        if (a_rd_data !== 64'd0 || b_rd_data !== 64'd0) $display("FAIL reset_rd_zero: got a=%h b=%h expected 0", a_rd_data, b_rd_data);
        else n_pass++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_ready === 1'b1 && ra == 0) ra = k;
            if (b_ready === 1'b1 && rb == 0) rb = k;
            if (a_ready !== 1'b1 && a_rd_data !== 64'd0) bad++;
            if (b_ready !== 1'b1 && b_rd_data !== 64'd0) bad++;
            if (ra != 0 && rb != 0) break;
        end
        n_total++;
        if (ra != 32) $display("FAIL ready_edge_a: got %0d expected 32", ra);
        else n_pass++;
        n_total++;
        if (rb != 8) $display("FAIL ready_edge_b: got %0d expected 8", rb);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL sweep_rd_gated: got %0d nonzero reads expected 0", bad);
        else n_pass++;
        load_presets();
    endtask

    task automatic test_presets();
        for (int i = 0; i < 32; i++) begin
            a_rd_index = {5'(31 - i), 5'(i)};
            #1;
            n_total++;
            if (a_rd_data[31:0] !== m_a[i]) $display("FAIL preset_a idx %0d: got %h expected %h", i, a_rd_data[31:0], m_a[i]);
            else n_pass++;
            n_total++;
            if (a_rd_data[63:32] !== m_a[31 - i]) $display("FAIL preset_a idx %0d: got %h expected %h", 31 - i, a_rd_data[63:32], m_a[31 - i]);
            else n_pass++;
        end
        a_rd_index = {5'd5, 5'd10};
        #1;
        n_total++;
        if (a_rd_data !== {32'd0, 32'h1001_0000}) $display("FAIL preset_r10_r5: got %h expected %h", a_rd_data, {32'd0, 32'h1001_0000});
        else n_pass++;
        b_rd_index = {3'd2, 3'd2, 3'd2, 3'd2};
        #1;
        n_total++;
        if (b_rd_data !== {4{16'h0002}}) $display("FAIL b_all_ports_r2: got %h expected %h", b_rd_data, {4{16'h0002}});
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            b_rd_index = {3'(7 - i), 3'd2, 3'(i + 1), 3'(i)};
            #1;
            n_total++;
            if (b_rd_data !== {m_b[7 - i], m_b[2], m_b[(i + 1) % 8], m_b[i]})
                $display("FAIL preset_b idx %0d: got %h expected %h", i, b_rd_data, {m_b[7 - i], m_b[2], m_b[(i + 1) % 8], m_b[i]});
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        drive_a(2'b01, 5'd7, 32'hDEAD_BEEF, 5'd0, 32'd0);
        a_rd_index = {5'd7, 5'd7};
        #1;
        n_total++;
        if (a_rd_data !== {2{32'hDEAD_BEEF}}) $display("FAIL bypass_a_same_cycle: got %h expected %h", a_rd_data, {2{32'hDEAD_BEEF}});
        else n_pass++;
        tick();
        commit_a(2'b01, 5'd7, 32'hDEAD_BEEF, 5'd0, 32'd0);
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        n_total++;
        if (a_rd_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL bypass_a_next_cycle: got %h expected deadbeef", a_rd_data[31:0]);
        else n_pass++;
        drive_b(2'b01, 3'd5, 16'hBEEF, 3'd0, 16'd0);
        b_rd_index = {4{3'd5}};
        #1;
        n_total++;
        if (b_rd_data !== 64'd0) $display("FAIL nobypass_b_same_cycle: got %h expected 0", b_rd_data);
        else n_pass++;
        tick();
        commit_b(2'b01, 3'd5, 16'hBEEF, 3'd0, 16'd0);
        drive_b(2'b00, 3'd0, 16'd0, 3'd0, 16'd0);
        #1;
        n_total++;
        if (b_rd_data !== {4{16'hBEEF}}) $display("FAIL nobypass_b_next_cycle: got %h expected %h", b_rd_data, {4{16'hBEEF}});
        else n_pass++;
    endtask

    task automatic test_same_index();
        drive_a(2'b11, 5'd3, 32'h1111, 5'd3, 32'h2222);
        a_rd_index = {5'd3, 5'd3};
        #1;
        n_total++;
        if (a_rd_data !== {2{32'h2222}}) $display("FAIL same_idx_bypass: got %h expected %h", a_rd_data, {2{32'h2222}});
        else n_pass++;
        tick();
        commit_a(2'b11, 5'd3, 32'h1111, 5'd3, 32'h2222);
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        n_total++;
        if (a_rd_data[31:0] !== 32'h2222) $display("FAIL same_idx_stored_a: got %h expected 2222", a_rd_data[31:0]);
        else n_pass++;
        drive_b(2'b11, 3'd6, 16'hAAAA, 3'd6, 16'h5555);
        b_rd_index = {4{3'd6}};
        tick();
        commit_b(2'b11, 3'd6, 16'hAAAA, 3'd6, 16'h5555);
        drive_b(2'b00, 3'd0, 16'd0, 3'd0, 16'd0);
        #1;
        n_total++;
        if (b_rd_data !== {4{16'h5555}}) $display("FAIL same_idx_stored_b: got %h expected %h", b_rd_data, {4{16'h5555}});
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        drive_a(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
        a_rd_index = {5'd0, 5'd0};
        #1;
        n_total++;
        if (a_rd_data !== 64'd0) $display("FAIL zero_reg_before: got %h expected 0", a_rd_data);
        else n_pass++;
        tick();
        commit_a(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        n_total++;
        if (a_rd_data !== 64'd0) $display("FAIL zero_reg_after: got %h expected 0", a_rd_data);
        else n_pass++;
        drive_b(2'b01, 3'd0, 16'h1234, 3'd1, 16'd0);
        b_rd_index = {4{3'd0}};
        tick();
        commit_b(2'b01, 3'd0, 16'h1234, 3'd1, 16'd0);
        drive_b(2'b00, 3'd0, 16'd0, 3'd0, 16'd0);
        #1;
        n_total++;
        if (b_rd_data[15:0] !== 16'h1234) $display("FAIL b_entry0_writable: got %h expected 1234", b_rd_data[15:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]  en, enb;
        logic [4:0]  ia, ib, r0, r1;
        logic [31:0] da, db, e0, e1;
        logic [2:0]  ja, jb;
        logic [15:0] ea, eb;
        logic [2:0]  rb [4];
        for (int n = 0; n < 150; n++) begin
            en = 2'($urandom_range(0, 3));
            ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ib = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
            da = $urandom; db = $urandom;
            r0 = ($urandom_range(0, 1) == 0) ? ia : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) == 0) ? ib : 5'($urandom_range(0, 31));
            drive_a(en, ia, da, ib, db);
            a_rd_index = {r1, r0};
            enb = 2'($urandom_range(0, 3));
            ja = 3'($urandom_range(0, 7));
            jb = ($urandom_range(0, 2) == 0) ? ja : 3'($urandom_range(0, 7));
            ea = 16'($urandom); eb = 16'($urandom);
            drive_b(enb, ja, ea, jb, eb);
            for (int p = 0; p < 4; p++) begin
                rb[p] = 3'($urandom_range(0, 7));
                b_rd_index[p*3 +: 3] = rb[p];
            end
            #1;
            e0 = exp_a(r0, en, ia, da, ib, db);
            e1 = exp_a(r1, en, ia, da, ib, db);
            n_total++;
            if (a_rd_data[31:0] !== e0) $display("FAIL rand_a_p0 it %0d idx %0d: got %h expected %h", n, r0, a_rd_data[31:0], e0);
            else n_pass++;
            n_total++;
            if (a_rd_data[63:32] !== e1) $display("FAIL rand_a_p1 it %0d idx %0d: got %h expected %h", n, r1, a_rd_data[63:32], e1);
            else n_pass++;
            for (int p = 0; p < 4; p++) begin
                n_total++;
                if (b_rd_data[p*16 +: 16] !== m_b[rb[p]])
                    $display("FAIL rand_b_p%0d it %0d idx %0d: got %h expected %h", p, n, rb[p], b_rd_data[p*16 +: 16], m_b[rb[p]]);
                else n_pass++;
            end
            tick();
            commit_a(en, ia, da, ib, db);
            commit_b(enb, ja, ea, jb, eb);
        end
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive_b(2'b00, 3'd0, 16'd0, 3'd0, 16'd0);
        for (int i = 0; i < 32; i++) begin
            a_rd_index = {5'd0, 5'(i)};
            b_rd_index = {4{3'(i % 8)}};
            #1;
            n_total++;
            if (a_rd_data[31:0] !== m_a[i]) $display("FAIL final_a idx %0d: got %h expected %h", i, a_rd_data[31:0], m_a[i]);
            else n_pass++;
            n_total++;
            if (b_rd_data[15:0] !== m_b[i % 8]) $display("FAIL final_b idx %0d: got %h expected %h", i % 8, b_rd_data[15:0], m_b[i % 8]);
            else n_pass++;
        end
    endtask

    task automatic test_clear_restart();
        int rk, bad;
        rk = 0; bad = 0;
        drive_a(2'b01, 5'd4, 32'h55, 5'd0, 32'd0);
        tick();
        commit_a(2'b01, 5'd4, 32'h55, 5'd0, 32'd0);
        drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        a_rd_index = {5'd1, 5'd4};
        #1;
        n_total++;
        if (a_rd_data[31:0] !== 32'h55) $display("FAIL r4_written: got %h expected 55", a_rd_data[31:0]);
        else n_pass++;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        drive_a(2'b11, 5'd4, 32'hBAD0_0001, 5'd9, 32'hBAD0_0002);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (a_ready !== 1'b0 || a_rd_data !== 64'd0) bad++;
        end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_ready === 1'b1) begin
                rk = k;
                drive_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
                break;
            end
            if (a_rd_data !== 64'd0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL restart_sweep_quiet: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_total++;
        if (rk != 32) $display("FAIL restart_ready_edge: got %0d expected 32", rk);
        else n_pass++;
        load_presets();
        for (int i = 0; i < 32; i++) begin
            a_rd_index = {5'd0, 5'(i)};
            #1;
            n_total++;
            if (a_rd_data[31:0] !== m_a[i]) $display("FAIL restart_preset idx %0d: got %h expected %h", i, a_rd_data[31:0], m_a[i]);
            else n_pass++;
        end
        a_rd_index = {5'd9, 5'd4};
        #1;
        n_total++;
        if (a_rd_data !== 64'd0) $display("FAIL restart_r4_r9_cleared: got %h expected 0", a_rd_data);
        else n_pass++;
    endtask

    initial begin
        a_clear = 1'b0; b_clear = 1'b0;
        a_rd_index = '0; b_rd_index = '0;
        a_wr_en = '0; a_wr_index = '0; a_wr_data = '0;
        b_wr_en = '0; b_wr_index = '0; b_wr_data = '0;
        tick();
        test_reset();
        test_presets();
        test_bypass();
        test_same_index();
        test_zero_reg();
        test_random();
        test_clear_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
